sum_of_squares_seq: RTL and testbench

- Iterative shift-add unit computing the magnitude-squared I^2 + Q^2 of a signed I/Q sample pair.
- Sits in the AM demodulation path directly upstream of the square-root stage and produces its N-bit unsigned radicand.
- One result per W+2 clocks; valid/ready handshake on both input and output sides.

---
 rtl/sum_of_squares_seq.sv | 125 ++++++++++++
 tb/tb_sum_of_squares_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sum_of_squares_seq.sv
// Iterative magnitude-squared unit: sum_sq = i_in^2 + q_in^2.
// Squares both |I| and |Q| with one shift-add step per clock (LSB first),
// W RUN cycles per sample, valid/ready handshake on both sides.
//
// state | meaning
// IDLE  | in_ready high, waiting for an input sample
// RUN   | one multiplier bit of |I| and |Q| accumulated per clock
// DONE  | result presented on sum_sq until out_ready accepts it
module sum_of_squares_seq #(
  parameter int W = 5,
  parameter int N = 2 * W
) (
  input  logic                Clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] i_in,
  input  logic signed [W-1:0] q_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        sum_sq
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  magi_q, magi_d;
  logic [W-1:0]  magq_q, magq_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  sum_sq_q, sum_sq_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W-1:0]  abs_i, abs_q;
  logic [N-1:0]  ext_i, ext_q;
  logic [N-1:0]  term_i, term_q;
  logic [N-1:0]  acc_next;

  // Magnitudes are taken unsigned in W bits so the most negative input maps to 2^(W-1) exactly.
  always_comb begin
    abs_i    = i_in[W-1] ? (~i_in + {{(W-1){1'b0}}, 1'b1}) : i_in;
    abs_q    = q_in[W-1] ? (~q_in + {{(W-1){1'b0}}, 1'b1}) : q_in;
    ext_i    = {{(N-W){1'b0}}, magi_q};
    ext_q    = {{(N-W){1'b0}}, magq_q};
    term_i   = magi_q[cnt_q] ? (ext_i << cnt_q) : '0;
    term_q   = magq_q[cnt_q] ? (ext_q << cnt_q) : '0;
    acc_next = acc_q + term_i + term_q;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    sum_sq    = sum_sq_q;
  end

  // Datapath next values: load on accept, accumulate in RUN, capture the result on the last bit.
  always_comb begin
    magi_d   = magi_q;
    magq_d   = magq_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sum_sq_d = sum_sq_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          magi_d = abs_i;
          magq_d = abs_q;
          acc_d  = '0;
          cnt_d  = '0;
        end
      end
      RUN: begin
        acc_d = acc_next;
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == LAST) sum_sq_d = acc_next;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any in-flight result.
  always_ff @(posedge Clock) begin
    if (!reset_n) begin
      magi_q   <= '0;
      magq_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sum_sq_q <= '0;
    end else begin
      magi_q   <= magi_d;
      magq_q   <= magq_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sum_sq_q <= sum_sq_d;
    end
  end

endmodule

// File: tb/tb_sum_of_squares_seq.sv
// Self-checking bench for sum_of_squares_seq (W=5): directed cases plus a random sweep.
module tb_sum_of_squares_seq;
  localparam int W = 5;
  localparam int N = 2 * W;

  logic                Clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] i_in = '0;
  logic signed [W-1:0] q_in = '0;
  logic                in_ready;
  logic                out_valid;
  logic [N-1:0]        sum_sq;

  int tests_run = 0;
  int tests_failed = 0;

  sum_of_squares_seq #(.W(W), .N(N)) dut (
    .Clock     (Clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i_in      (i_in),
    .q_in      (q_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_sq    (sum_sq)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_sq(input int i, input int q);
    return i * i + q * q;
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Present one sample, measure latency, check the result, optionally stall the output.
  task automatic do_sample(input int i, input int q, input int stall);
    int   lat;
    int   exp;
    logic ok;
    exp = ref_sq(i, q);
    check("accept_ready", {31'd0, in_ready}, 1);
    in_valid  = 1'b1;
    i_in      = W'(i);
    q_in      = W'(q);
    out_ready = (stall == 0);
    tick();
    in_valid = 1'b0;
    i_in     = W'($urandom);
    q_in     = W'($urandom);
    lat = 0;
    ok  = 1'b1;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (in_ready !== 1'b0) ok = 1'b0;
      tick();
      lat++;
    end
    check("latency", lat, 5);
    check("busy_not_ready", {31'd0, ok}, 1);
    check("sum", {22'd0, sum_sq}, exp);
    if (stall > 0) begin
      ok       = 1'b1;
      in_valid = 1'b1;
      repeat (stall) begin
        tick();
        if (out_valid !== 1'b1 || sum_sq !== N'(exp) || in_ready !== 1'b0) ok = 1'b0;
      end
      check("stall_hold", {31'd0, ok}, 1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    tick();
    check("release", {30'd0, out_valid, in_ready}, 2'b01);
    check("sum_kept", {22'd0, sum_sq}, exp);
  endtask

  initial begin
    int   samp_i [3];
    int   samp_q [3];
    int   idx, got, edge_n, last_edge, low_cnt;
    int   ri, rq, st;
    logic rdy;
    logic ok;

    // Reset state
    reset_n = 1'b0;
    tick();
    tick();
    check("reset_state", {29'd0, in_ready, out_valid, |sum_sq}, 3'b100);
    reset_n = 1'b1;

    // Directed values including signed extremes
    do_sample(3, 4, 0);
    do_sample(-16, -16, 0);
    do_sample(15, -16, 0);
    do_sample(0, 0, 0);

    // Backpressure
    do_sample(3, 4, 10);

    // Back-to-back with in_valid held high
    samp_i = '{1, 2, -7};
    samp_q = '{1, -2, 5};
    idx = 0; got = 0; edge_n = 0; last_edge = 0; low_cnt = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    i_in = W'(samp_i[0]);
    q_in = W'(samp_q[0]);
    while (got < 3 && edge_n < 60) begin
      rdy = in_ready;
      if (!in_ready) low_cnt++;
      tick();
      edge_n++;
      if (rdy && idx < 3) begin
        idx++;
        if (idx < 3) begin
          i_in = W'(samp_i[idx]);
          q_in = W'(samp_q[idx]);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        check("b2b_sum", {22'd0, sum_sq}, ref_sq(samp_i[got], samp_q[got]));
        if (got > 0) check("b2b_spacing", edge_n - last_edge, 7);
        last_edge = edge_n;
        got++;
      end
    end
    check("b2b_count", got, 3);
    check("b2b_ready_low", low_cnt, 17);
    in_valid = 1'b0;
    tick();
    check("b2b_idle", {31'd0, in_ready}, 1);

    // Reset in the middle of RUN
    in_valid = 1'b1;
    i_in = W'(9);
    q_in = W'(9);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrun_reset", {29'd0, in_ready, out_valid, |sum_sq}, 3'b100);
    ok = 1'b1;
    repeat (6) begin
      tick();
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    check("midrun_no_output", {31'd0, ok}, 1);
    do_sample(-1, 2, 0);

    // Random sweep with random output stalls
    for (int n = 0; n < 1000; n++) begin
      ri = int'($urandom_range(0, 31)) - 16;
      rq = int'($urandom_range(0, 31)) - 16;
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      do_sample(ri, rq, st);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
